// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - dual-lane in-order instruction queue between fetch and id_stage
// Optional IQ_STAT_EN adds full/empty cycle counters.
package inst_queue_pkg;
  typedef logic [5:0] exception_t;
  localparam exception_t EXC_NONE = 6'h00;
  localparam exception_t EXC_ADEF = 6'h08;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_branch_taken;
    logic [31:0] pred_branch_target;
    logic        have_exception;
    exception_t  exception_type;
  } iq_entry_t;
endpackage

module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  output logic        iq_allowin,
  input  logic        if_a_valid,
  input  logic        if_b_valid,
  input  logic [31:0] if_a_pc,
  input  logic [31:0] if_b_pc,
  input  logic [31:0] if_a_inst,
  input  logic [31:0] if_b_inst,
  input  logic        if_a_pred_branch_taken,
  input  logic        if_b_pred_branch_taken,
  input  logic [31:0] if_a_pred_branch_target,
  input  logic [31:0] if_b_pred_branch_target,
  input  logic        if_a_have_exception,
  input  logic        if_b_have_exception,
  input  exception_t  if_a_exception_type,
  input  exception_t  if_b_exception_type,
  input  logic [1:0]  id_consume_inst,
  output logic        a_valid,
  output logic        b_valid,
  output logic [31:0] a_pc,
  output logic [31:0] b_pc,
  output logic [31:0] a_inst,
  output logic [31:0] b_inst,
  output logic        a_pred_branch_taken,
  output logic        b_pred_branch_taken,
  output logic [31:0] a_pred_branch_target,
  output logic [31:0] b_pred_branch_target,
  output logic        a_have_exception,
  output logic        b_have_exception,
  output exception_t  a_exception_type,
  output exception_t  b_exception_type
`ifdef IQ_STAT_EN
  ,
  output logic [31:0] iq_stat_full_cycles,
  output logic [31:0] iq_stat_empty_cycles
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  iq_entry_t      mem [DEPTH];
  logic [PW-1:0]  head, tail, b_slot, head_nxt;
  logic [CW-1:0]  count;
  iq_entry_t      in_a, in_b, head_e, next_e;
  logic           do_push;
  logic [1:0]     push_n, pop_n, cons_eff;

  always_comb begin
    in_a = {if_a_pc, if_a_inst, if_a_pred_branch_taken, if_a_pred_branch_target,
            if_a_have_exception, if_a_exception_type};
    in_b = {if_b_pc, if_b_inst, if_b_pred_branch_taken, if_b_pred_branch_target,
            if_b_have_exception, if_b_exception_type};
    iq_allowin = (count <= CW'(DEPTH - 2));
    do_push    = iq_allowin && !flush;
    push_n     = do_push ? ({1'b0, if_a_valid} + {1'b0, if_b_valid}) : 2'd0;
    // An illegal consume of 3 pops nothing.
    cons_eff   = (id_consume_inst == 2'd3) ? 2'd0 : id_consume_inst;
    pop_n      = (count < CW'(cons_eff)) ? count[1:0] : cons_eff;
    // A lone lane b is compacted into the tail slot.
    b_slot     = if_a_valid ? tail + PW'(1) : tail;
    head_nxt   = head + PW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push && if_a_valid) mem[tail]   <= in_a;
      if (do_push && if_b_valid) mem[b_slot] <= in_b;
      tail  <= tail + PW'(push_n);
      head  <= head + PW'(pop_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  always @(posedge clk) begin
    if (resetn) assert (id_consume_inst != 2'd3);
  end

  always_comb begin
    head_e = mem[head];
    next_e = mem[head_nxt];
  end

  assign a_valid              = (count >= CW'(1));
  assign b_valid              = (count >= CW'(2));
  assign a_pc                 = head_e.pc;
  assign a_inst               = head_e.inst;
  assign a_pred_branch_taken  = head_e.pred_branch_taken;
  assign a_pred_branch_target = head_e.pred_branch_target;
  assign a_have_exception     = head_e.have_exception;
  assign a_exception_type     = head_e.exception_type;
  assign b_pc                 = next_e.pc;
  assign b_inst               = next_e.inst;
  assign b_pred_branch_taken  = next_e.pred_branch_taken;
  assign b_pred_branch_target = next_e.pred_branch_target;
  assign b_have_exception     = next_e.have_exception;
  assign b_exception_type     = next_e.exception_type;

`ifdef IQ_STAT_EN
  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iq_stat_full_cycles  <= '0;
      iq_stat_empty_cycles <= '0;
    end else begin
      if (!iq_allowin) iq_stat_full_cycles <= iq_stat_full_cycles + 32'd1;
      if (count == '0 && !flush) iq_stat_empty_cycles <= iq_stat_empty_cycles + 32'd1;
    end
  end
`endif
endmodule
